// File: rtl/pcpi_pkg.sv
// ---------------------------------------------------------------------------
// pcpi_pkg
// Shared types and constants for the multi-channel PCPI dispatcher.
//   state_e          : dispatcher FSM states
//   OPC_OP_FP        : RISC-V OP-FP major opcode (FPU channel)
//   OPC_CUSTOM0      : RISC-V custom-0 major opcode (accelerator channel)
//   PCPI_ACK_WINDOW  : cycles the picorv32 core waits for wait/ready before
//                      raising the illegal-instruction trap
//   MAX_CP           : largest supported channel count (3-bit channel index)
// ---------------------------------------------------------------------------
package pcpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [6:0] OPC_OP_FP   = 7'h53;
  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;

  localparam int unsigned PCPI_ACK_WINDOW = 16;
  localparam int unsigned MAX_CP          = 8;

endpackage

// File: rtl/pcpi_match_decoder.sv
// ---------------------------------------------------------------------------
// pcpi_match_decoder
// Combinational instruction decoder: each channel i claims the instruction
// when (insn & MATCH_MASK[i]) == MATCH_VAL[i]. When several channels claim
// it, the lowest index wins.
// Ports:
//   insn   in   32      instruction word offered by the core
//   hit    out  1       at least one channel matches
//   sel    out  3       index of the lowest matching channel (0 if no hit)
//   grant  out  NUM_CP  one-hot of sel, all zero when there is no hit
// ---------------------------------------------------------------------------
module pcpi_match_decoder #(
  parameter int                    NUM_CP     = 2,
  parameter logic [NUM_CP*32-1:0]  MATCH_VAL  = {32'h0000000B, 32'h00000053},
  parameter logic [NUM_CP*32-1:0]  MATCH_MASK = {32'h0000007F, 32'h0000007F}
) (
  input  logic [31:0]       insn,
  output logic              hit,
  output logic [2:0]        sel,
  output logic [NUM_CP-1:0] grant
);

  logic [NUM_CP-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      match[i] = ((insn & MATCH_MASK[32*i +: 32]) == MATCH_VAL[32*i +: 32]);
    end
  end

  // Scan from the top down so the last assignment is the lowest match.
  always_comb begin
    hit   = |match;
    sel   = '0;
    grant = '0;
    for (int i = NUM_CP - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel      = 3'(i);
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcpi_dispatch.sv
// ---------------------------------------------------------------------------
// pcpi_dispatch
// Routes instructions from the picorv32 PCPI port to one of NUM_CP
// coprocessors, with a declined-instruction window, a busy-timeout watchdog,
// abort on core withdrawal and a sticky timeout error.
//
// Handshake (all outputs registered):
//   The core holds pcpiValidIn with a stable instruction until it sees
//   pcpiReadyOut or gives up and drops valid. A dispatch raises exactly one
//   cpValidOut bit together with pcpiWaitOut one edge after valid is seen.
//   The selected coprocessor answers with cpReadyIn (result done, one beat)
//   or cpWaitIn (accepted, still working) within ACK_CYCLES cycles;
//   otherwise the instruction is declined silently. Completion produces a
//   single-cycle pcpiReadyOut with pcpiWrOut/pcpiRdOut captured from the
//   selected channel. After any end of an instruction the dispatcher waits
//   for pcpiValidIn to fall before it will accept another one.
//
// Ports:
//   clkIn, rstLowIn              clock, asynchronous active-low reset
//   pcpiValidIn/InstIn/Rs1In/Rs2In   core request
//   pcpiWrOut/RdOut/WaitOut/ReadyOut core response
//   cpValidOut [NUM_CP]          one-hot valid to coprocessors
//   cpInstOut/Rs1Out/Rs2Out      latched request, broadcast to all channels
//   cpWrIn/RdIn/WaitIn/ReadyIn   per-channel response (RdIn packed 32/chan)
//   errClrIn                     clears the sticky timeout flag
//   errTimeoutOut, errChanOut    sticky timeout flag, channel of last timeout
//   dbg_state                    current FSM state (pcpi_pkg::state_e)
// ---------------------------------------------------------------------------
module pcpi_dispatch
  import pcpi_pkg::*;
#(
  parameter int                    NUM_CP         = 2,
  parameter logic [NUM_CP*32-1:0]  MATCH_VAL      = {32'h0000000B, 32'h00000053},
  parameter logic [NUM_CP*32-1:0]  MATCH_MASK     = {32'h0000007F, 32'h0000007F},
  parameter int                    ACK_CYCLES     = 4,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                 clkIn,
  input  logic                 rstLowIn,
  input  logic                 pcpiValidIn,
  input  logic [31:0]          pcpiInstIn,
  input  logic [31:0]          pcpiRs1In,
  input  logic [31:0]          pcpiRs2In,
  output logic                 pcpiWrOut,
  output logic [31:0]          pcpiRdOut,
  output logic                 pcpiWaitOut,
  output logic                 pcpiReadyOut,
  output logic [NUM_CP-1:0]    cpValidOut,
  output logic [31:0]          cpInstOut,
  output logic [31:0]          cpRs1Out,
  output logic [31:0]          cpRs2Out,
  input  logic [NUM_CP-1:0]    cpWrIn,
  input  logic [NUM_CP*32-1:0] cpRdIn,
  input  logic [NUM_CP-1:0]    cpWaitIn,
  input  logic [NUM_CP-1:0]    cpReadyIn,
  input  logic                 errClrIn,
  output logic                 errTimeoutOut,
  output logic [2:0]           errChanOut,
  output logic [1:0]           dbg_state
);

  localparam int ACK_W  = $clog2(ACK_CYCLES + 1);
  localparam int BUSY_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_CYCLES - 1);
  localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q;
  logic [2:0]          sel_q;
  logic [ACK_W-1:0]    ack_cnt;
  logic [BUSY_W-1:0]   busy_cnt;

  logic                dec_hit;
  logic [2:0]          dec_sel;
  logic [NUM_CP-1:0]   dec_grant;

  logic                sel_ready;
  logic                sel_wait;
  logic                sel_wr;
  logic [31:0]         sel_rd;

  assign dbg_state = state_q;

  pcpi_match_decoder #(
    .NUM_CP     (NUM_CP),
    .MATCH_VAL  (MATCH_VAL),
    .MATCH_MASK (MATCH_MASK)
  ) u_decoder (
    .insn  (pcpiInstIn),
    .hit   (dec_hit),
    .sel   (dec_sel),
    .grant (dec_grant)
  );

  // Only the latched channel is ever looked at; other channels are muted here.
  always_comb begin
    sel_ready = 1'b0;
    sel_wait  = 1'b0;
    sel_wr    = 1'b0;
    sel_rd    = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      if (sel_q == 3'(i)) begin
        sel_ready = cpReadyIn[i];
        sel_wait  = cpWaitIn[i];
        sel_wr    = cpWrIn[i];
        sel_rd    = cpRdIn[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      ack_cnt       <= '0;
      busy_cnt      <= '0;
      cpValidOut    <= '0;
      cpInstOut     <= '0;
      cpRs1Out      <= '0;
      cpRs2Out      <= '0;
      pcpiWaitOut   <= 1'b0;
      pcpiReadyOut  <= 1'b0;
      pcpiWrOut     <= 1'b0;
      pcpiRdOut     <= '0;
      errTimeoutOut <= 1'b0;
      errChanOut    <= '0;
    end else begin
      // Ready and write-enable are single-cycle pulses.
      pcpiReadyOut <= 1'b0;
      pcpiWrOut    <= 1'b0;

      // Clear first so a timeout raised below in the same cycle wins.
      if (errClrIn) errTimeoutOut <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pcpiValidIn && dec_hit) begin
            cpInstOut   <= pcpiInstIn;
            cpRs1Out    <= pcpiRs1In;
            cpRs2Out    <= pcpiRs2In;
            sel_q       <= dec_sel;
            cpValidOut  <= dec_grant;
            pcpiWaitOut <= 1'b1;
            ack_cnt     <= '0;
            state_q     <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (!pcpiValidIn) begin
            cpValidOut  <= '0;
            pcpiWaitOut <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (sel_ready) begin
            pcpiReadyOut <= 1'b1;
            pcpiWrOut    <= sel_wr;
            pcpiRdOut    <= sel_rd;
            cpValidOut   <= '0;
            pcpiWaitOut  <= 1'b0;
            state_q      <= ST_DRAIN;
          end else if (sel_wait) begin
            busy_cnt <= '0;
            state_q  <= ST_BUSY;
          end else if (ack_cnt == ACK_LAST) begin
            // Declined: the core's own ack window turns this into a trap.
            cpValidOut  <= '0;
            pcpiWaitOut <= 1'b0;
            state_q     <= ST_DRAIN;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        ST_BUSY: begin
          if (!pcpiValidIn) begin
            cpValidOut  <= '0;
            pcpiWaitOut <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (sel_ready) begin
            pcpiReadyOut <= 1'b1;
            pcpiWrOut    <= sel_wr;
            pcpiRdOut    <= sel_rd;
            cpValidOut   <= '0;
            pcpiWaitOut  <= 1'b0;
            state_q      <= ST_DRAIN;
          end else if (busy_cnt == BUSY_LAST) begin
            cpValidOut    <= '0;
            pcpiWaitOut   <= 1'b0;
            errTimeoutOut <= 1'b1;
            errChanOut    <= sel_q;
            state_q       <= ST_DRAIN;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end

        ST_DRAIN: begin
          // Hold off until the core releases the instruction so it is
          // never dispatched twice.
          if (!pcpiValidIn) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pcpi_dispatch.md
Name: pcpi_dispatch

Overview:
- Multi-channel PCPI dispatcher between the picorv32 PCPI port and NUM_CP coprocessors, for example the FPU plus custom accelerators.
- Each instruction offered by the core is decoded against a per-channel match/mask, then registered and forwarded to one coprocessor.
- Handshake, result and write-enable are returned to the core.
- Adds features a single point-to-point attachment lacks: a declined-instruction window, a busy-timeout watchdog, clean abort on core withdrawal, and sticky error reporting.

Parameters:
- NUM_CP, 2, number of coprocessor channels (1..8).
- MATCH_VAL, {32'h0000000B, 32'h00000053}, packed NUM_CP*32; channel i match value in bits [32i+31:32i].
- MATCH_MASK, {32'h0000007F, 32'h0000007F}, packed NUM_CP*32; channel i matches when (insn & mask_i) == val_i.
- ACK_CYCLES, 4, cycles after dispatch the selected channel has to assert wait or ready.
- TIMEOUT_CYCLES, 255, maximum cycles in BUSY before forced abort.

Ports:
- clkIn  in  1  clock
- rstLowIn  in  1  asynchronous active-low reset
- pcpiValidIn  in  1  core PCPI valid
- pcpiInstIn  in  32  instruction word
- pcpiRs1In  in  32  operand 1
- pcpiRs2In  in  32  operand 2
- pcpiWrOut  out  1  result write enable to core
- pcpiRdOut  out  32  result to core
- pcpiWaitOut  out  1  wait to core
- pcpiReadyOut  out  1  ready to core
- cpValidOut  out  NUM_CP  one-hot valid to coprocessors
- cpInstOut  out  32  latched instruction, broadcast
- cpRs1Out  out  32  latched rs1, broadcast
- cpRs2Out  out  32  latched rs2, broadcast
- cpWrIn  in  NUM_CP  per-channel write enable
- cpRdIn  in  NUM_CP*32  per-channel result, packed
- cpWaitIn  in  NUM_CP  per-channel wait
- cpReadyIn  in  NUM_CP  per-channel ready
- errClrIn  in  1  clears sticky error
- errTimeoutOut  out  1  sticky busy-timeout flag
- errChanOut  out  3  channel index of last timeout

Behaviour:
- Reset (rstLowIn=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including latched insn/rs registers, counters and error flags.
- All outputs are registered.
- States: IDLE, ACK, BUSY, DRAIN.
- IDLE:
  - If pcpiValidIn=1 and at least one channel matches: latch insn/rs1/rs2, sel = lowest matching index, go to ACK.
  - Next edge: cpValidOut[sel]=1 and pcpiWaitOut=1. Dispatch latency is 1 cycle.
  - No match: stay IDLE with all outputs 0. The core's own timeout raises the illegal-instruction trap.
- ACK:
  - Counter ackCnt increments each cycle.
  - cpReadyIn[sel]=1 → complete.
  - Else cpWaitIn[sel]=1 → BUSY, busyCnt=0.
  - Else ackCnt reaches ACK_CYCLES-1 → decline: cpValidOut=0, pcpiWaitOut=0, go to DRAIN. No error is raised.
- BUSY:
  - busyCnt increments each cycle.
  - cpReadyIn[sel]=1 → complete.
  - busyCnt reaches TIMEOUT_CYCLES-1 → cpValidOut=0, pcpiWaitOut=0, errTimeoutOut=1, errChanOut=sel, go to DRAIN.
  - Ready in the same cycle as expiry: ready wins, no error.
- Complete:
  - Next edge: pcpiReadyOut=1 for exactly one cycle.
  - pcpiWrOut=cpWrIn[sel] and pcpiRdOut=cpRdIn[sel], both captured at that edge.
  - cpValidOut=0 and pcpiWaitOut=0 at that edge.
  - Go to DRAIN.
  - pcpiRdOut holds its value until the next completion; pcpiWrOut returns to 0 with ready.
- DRAIN:
  - Wait for pcpiValidIn=0, then go to IDLE.
  - The same instruction is never re-dispatched.
- Core withdrawal: pcpiValidIn=0 in ACK or BUSY aborts. On the next edge all cp/pcpi handshake outputs are 0, state is IDLE, and no error is raised.
- Non-selected channel inputs are ignored at all times.
- cpValidOut is at most one-hot.
- Error clear:
  - errClrIn=1 clears errTimeoutOut.
  - A timeout in the same cycle as errClrIn sets errTimeoutOut (set wins).
- Reset asserted mid-operation returns to IDLE immediately, with all outputs 0.

Decomposition:
- Package pcpi_pkg holds:
  - state enum (IDLE/ACK/BUSY/DRAIN);
  - opcode constants OPC_OP_FP=7'h53 and OPC_CUSTOM0=7'h0B;
  - the PCPI default-ack window constant (16) for the core's timeout, referenced by the bench.
- Sub-module pcpi_match_decoder: combinational per-channel match plus lowest-index priority encoder. Outputs hit and sel.

Test Plan:
1. FP add: insn=32'h0020F0D3 (opcode 0x53), rs1=32'h3F800000, rs2=32'h40000000; ch0 asserts wait at cycle 2 and ready at cycle 6 with wr=1, rd=32'h40400000 → cpValidOut=2'b01 one cycle after valid; pcpiReadyOut pulses one cycle with pcpiRdOut=32'h40400000 and pcpiWrOut=1; DRAIN until valid drops.
2. Custom-0 insn=32'h0000000B → cpValidOut=2'b10; ch1 ready immediately with wr=0 → pcpiReadyOut=1, pcpiWrOut=0; ch0 signals ignored.
3. Unmatched insn=32'h00000033 → all outputs remain 0 for 20 cycles; no error.
4. Decline: ch0 is silent for 4 cycles → cpValidOut and pcpiWaitOut drop on cycle 5; errTimeoutOut=0.
5. Timeout with TIMEOUT_CYCLES=8: ch1 holds wait indefinitely → errTimeoutOut=1, errChanOut=1, valid/wait dropped; errClrIn pulse clears the flag; same-cycle ready+expiry variant → ready, no error.
6. Abort: pcpiValidIn drops in BUSY → IDLE next edge with outputs 0. Reset asserted mid-BUSY → immediate zero outputs.
